// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, field positions, write masks and exception codes.
package cp0_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned EXC_W   = 5;
    localparam int unsigned IP_W    = 6;
    localparam int unsigned PRESC_W = 8;

    localparam logic [ADDR_W-1:0] CP0_COUNT   = 5'd9;
    localparam logic [ADDR_W-1:0] CP0_COMPARE = 5'd11;
    localparam logic [ADDR_W-1:0] CP0_SR      = 5'd12;
    localparam logic [ADDR_W-1:0] CP0_CAUSE   = 5'd13;
    localparam logic [ADDR_W-1:0] CP0_EPC     = 5'd14;
    localparam logic [ADDR_W-1:0] CP0_PRID    = 5'd15;

    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned IP_LO    = 10;
    localparam int unsigned IP_HI    = 15;
    localparam int unsigned EXC_LO   = 2;
    localparam int unsigned EXC_HI   = 6;
    localparam int unsigned CAUSE_TI = 30;
    localparam int unsigned CAUSE_BD = 31;

    localparam logic [DATA_W-1:0] SR_WMASK  = 32'h0000_FC03;
    localparam logic [DATA_W-1:0] EPC_WMASK = 32'hFFFF_FFFC;

    localparam logic [EXC_W-1:0] EXC_INT = 5'd0;

    function automatic logic [DATA_W-1:0] cause_pack(input logic bd, input logic ti,
                                                     input logic [IP_W-1:0] ip,
                                                     input logic [EXC_W-1:0] exc);
        logic [DATA_W-1:0] v;
        v                 = '0;
        v[CAUSE_BD]       = bd;
        v[CAUSE_TI]       = ti;
        v[IP_HI:IP_LO]    = ip;
        v[EXC_HI:EXC_LO]  = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer_core.sv
// Prescaled free-running Count with a Compare register and a sticky compare-match flag.
module cp0_timer_core
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              ti,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(COUNT_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               match;

    assign tick  = (presc == PRESC_MAX);
    assign match = tick && ((count + DATA_W'(1)) == compare);

    // Software writes take priority over the tick; a Compare write always acknowledges TI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            count   <= '0;
            compare <= '1;
            ti      <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count + DATA_W'(1);
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (match) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_timer.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId, exception/interrupt request and capture, plus timer.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned       NUM_HWINT = 5,
    parameter int unsigned       COUNT_DIV = 1,
    parameter logic [DATA_W-1:0] PRID_VAL  = 32'h0000_7007
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [ADDR_W-1:0]    CP0Add,
    input  logic [DATA_W-1:0]    CP0In,
    input  logic [DATA_W-1:0]    VPC,
    input  logic                 BDIn,
    input  logic [EXC_W-1:0]     ExcCodeIn,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 EXLClr,
    output logic [DATA_W-1:0]    CP0Out,
    output logic [DATA_W-1:0]    EPCOut,
    output logic                 Req,
    output logic                 TimerIrq
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_n;
    logic [DATA_W-1:0] epc_q;
    logic [IP_W-1:0]   ip_q;
    logic [EXC_W-1:0]  exc_q;
    logic              bd_q;

    logic [IP_W-1:0]   ip_live;
    logic              int_pend;
    logic              capture;
    logic              wr;
    logic              ti;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;

    // Live IP: hardware lines from bit 0 upward, timer on the top bit.
    always_comb begin
        ip_live = '0;
        for (int unsigned k = 0; k < NUM_HWINT; k++)
            ip_live[k] = HWInt[k];
        ip_live[IP_W-1] = ti;
    end

    assign int_pend = sr_q[SR_IE] & ~sr_q[SR_EXL] & (|(sr_q[IP_HI:IP_LO] & ip_live));
    assign Req      = int_pend | (ExcCodeIn != EXC_INT);
    assign capture  = Req & ~sr_q[SR_EXL];
    assign wr       = en & ~Req;

    cp0_timer_core #(
        .COUNT_DIV (COUNT_DIV)
    ) u_core (
        .clk        (clk),
        .rst        (reset),
        .count_we   (wr && (CP0Add == CP0_COUNT)),
        .compare_we (wr && (CP0Add == CP0_COMPARE)),
        .wdata      (CP0In),
        .ti         (ti),
        .count      (count),
        .compare    (compare)
    );

    // EXL priority: Req sets, then eret clears, then an mtc0 to SR.
    always_comb begin
        sr_n = sr_q;
        if (wr && (CP0Add == CP0_SR))
            sr_n = CP0In & SR_WMASK;
        if (EXLClr)
            sr_n[SR_EXL] = 1'b0;
        if (Req)
            sr_n[SR_EXL] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            epc_q <= '0;
            ip_q  <= '0;
            exc_q <= '0;
            bd_q  <= 1'b0;
        end else begin
            sr_q <= sr_n;
            ip_q <= ip_live;
            if (capture) begin
                exc_q <= int_pend ? EXC_INT : ExcCodeIn;
                bd_q  <= BDIn;
                epc_q <= BDIn ? VPC - DATA_W'(4) : VPC;
            end else if (wr && (CP0Add == CP0_EPC)) begin
                epc_q <= CP0In & EPC_WMASK;
            end
        end
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            CP0_COUNT:   CP0Out = count;
            CP0_COMPARE: CP0Out = compare;
            CP0_SR:      CP0Out = sr_q;
            CP0_CAUSE:   CP0Out = cause_pack(bd_q, ti, ip_q, exc_q);
            CP0_EPC:     CP0Out = epc_q;
            CP0_PRID:    CP0Out = PRID_VAL;
            default:     CP0Out = '0;
        endcase
    end

    assign EPCOut   = epc_q;
    assign TimerIrq = ti;

endmodule

// File: tb/tb_cp0_timer.sv
// Directed and randomized bench for cp0_timer against a cycle-level behavioural model.
module tb_cp0_timer;

    localparam int unsigned NHW  = 5;
    localparam int unsigned DIV  = 4;
    localparam logic [31:0] PRID = 32'h0000_7007;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0;
    logic [4:0]     CP0Add = '0;
    logic [31:0]    CP0In = '0;
    logic [31:0]    VPC = '0;
    logic           BDIn = 1'b0;
    logic [4:0]     ExcCodeIn = '0;
    logic [NHW-1:0] HWInt = '0;
    logic           EXLClr = 1'b0;
    logic [31:0]    CP0Out;
    logic [31:0]    EPCOut;
    logic           Req;
    logic           TimerIrq;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [31:0] m_count, m_compare, m_epc;
    int          m_presc;
    logic        m_ti, m_ie, m_exl, m_bd;
    logic [5:0]  m_im, m_ipq;
    logic [4:0]  m_exc;

    cp0_timer #(
        .NUM_HWINT (NHW),
        .COUNT_DIV (DIV),
        .PRID_VAL  (PRID)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .CP0Out    (CP0Out),
        .EPCOut    (EPCOut),
        .Req       (Req),
        .TimerIrq  (TimerIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] m_ip();
        logic [5:0] v;
        v = '0;
        for (int i = 0; i < NHW; i++) v[i] = HWInt[i];
        v[5] = m_ti;
        return v;
    endfunction

    function automatic logic m_pend();
        return m_ie && !m_exl && ((m_im & m_ip()) != 6'd0);
    endfunction

    function automatic logic m_req();
        return m_pend() || (ExcCodeIn != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ipq) << 10) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_count = 0; m_compare = 32'hFFFF_FFFF; m_epc = 0; m_presc = 0;
        m_ti = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ipq = 0; m_exc = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic m_step();
        logic [5:0] ipv;
        logic pend, req, wr, tick, hit;
        ipv  = m_ip();
        pend = m_pend();
        req  = pend || (ExcCodeIn != 5'd0);
        wr   = en && !req;
        tick = (m_presc == int'(DIV) - 1);
        hit  = tick && (m_count + 32'd1 == m_compare);
        m_presc = (m_presc + 1) % int'(DIV);
        if (wr && CP0Add == 5'd11) begin
            m_compare = CP0In;
            m_ti = 0;
        end else if (hit) begin
            m_ti = 1;
        end
        if (wr && CP0Add == 5'd9) m_count = CP0In;
        else if (tick) m_count = m_count + 32'd1;
        m_ipq = ipv;
        if (req && !m_exl) begin
            m_exc = pend ? 5'd0 : ExcCodeIn;
            m_bd  = BDIn;
            m_epc = BDIn ? VPC - 32'd4 : VPC;
        end
        if (wr && CP0Add == 5'd12) begin
            m_im = CP0In[15:10]; m_exl = CP0In[1]; m_ie = CP0In[0];
        end
        if (wr && CP0Add == 5'd14) m_epc = CP0In & 32'hFFFF_FFFC;
        if (req) m_exl = 1;
        else if (EXLClr) m_exl = 0;
    endtask

    // One clock cycle: check at the falling edge, then let the rising edge happen.
    task automatic cyc();
        @(negedge clk);
        #1;
        n_vec++;
        chk("req", 32'(Req), 32'(m_req()));
        chk("rd", CP0Out, m_read(CP0Add));
        chk("epcout", EPCOut, m_epc);
        chk("timerirq", 32'(TimerIrq), 32'(m_ti));
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; ExcCodeIn = 0; EXLClr = 0; BDIn = 0; HWInt = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1; CP0Add = a; CP0In = d;
        cyc();
        en = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; checked before the next edge.
    task automatic do_reset();
        en = 0; ExcCodeIn = 0; EXLClr = 0;
        #3 reset = 1;
        #1;
        n_vec++;
        chk("rst_req", 32'(Req), 32'd0);
        CP0Add = 5'd12;
        #1 chk("rst_sr", CP0Out, 32'd0);
        CP0Add = 5'd11;
        #1 chk("rst_compare", CP0Out, 32'hFFFF_FFFF);
        chk("rst_epc", EPCOut, 32'd0);
        chk("rst_ti", 32'(TimerIrq), 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        m_reset();
    endtask

    initial begin
        logic [31:0] t;
        @(posedge clk);
        #1;
        do_reset();
        CP0Add = 5'd15;
        #1 chk("prid", CP0Out, PRID);

        // Interrupt in a delay slot
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 5'b00001; VPC = 32'h0000_3010; BDIn = 1;
        #1 chk("req_hwint", 32'(Req), 32'd1);
        cyc();
        BDIn = 0; CP0Add = 5'd13;
        #1 chk("epc_bd", EPCOut, 32'h0000_300C);
        chk("cause_bd", CP0Out, 32'h8000_0400);
        CP0Add = 5'd12;
        #1 chk("sr_exl", CP0Out, 32'h0000_0403);
        cyc();
        HWInt = 5'b00011;
        #1 chk("req_nested", 32'(Req), 32'd0);
        cyc();
        idle();

        // Interrupt beats synchronous exception
        do_reset();
        mtc0(5'd12, 32'h0000_1001);
        HWInt = 5'b00100; ExcCodeIn = 5'd10;
        #1 chk("req_both", 32'(Req), 32'd1);
        cyc();
        idle(); CP0Add = 5'd13;
        #1 t = CP0Out;
        chk("exc_int", 32'(t[6:2]), 32'd0);
        do_reset();
        mtc0(5'd12, 32'h0000_0001);
        HWInt = 5'b00100; ExcCodeIn = 5'd10;
        #1 chk("req_exc", 32'(Req), 32'd1);
        cyc();
        idle(); CP0Add = 5'd13;
        #1 t = CP0Out;
        chk("exc_sync", 32'(t[6:2]), 32'd10);

        // mtc0 to EPC dropped under Req
        do_reset();
        en = 1; CP0Add = 5'd14; CP0In = 32'h1234_5678; ExcCodeIn = 5'd4; VPC = 32'h0000_4000;
        cyc();
        idle();
        #1 chk("epc_drop", EPCOut, 32'h0000_4000);

        // Req beats eret; SR write mask
        do_reset();
        ExcCodeIn = 5'd8; EXLClr = 1;
        cyc();
        idle(); CP0Add = 5'd12;
        #1 chk("exl_hold", CP0Out, 32'h0000_0002);
        mtc0(5'd12, 32'hFFFF_FFFF);
        #1 chk("sr_mask", CP0Out, 32'h0000_FC03);

        // Timer: COUNT_DIV = 4, Compare = 3 raises TI on the 12th edge
        do_reset();
        mtc0(5'd11, 32'd3);
        repeat (10) cyc();
        #1 chk("ti_early", 32'(TimerIrq), 32'd0);
        cyc();
        #1 chk("ti_set", 32'(TimerIrq), 32'd1);
        mtc0(5'd12, 32'h0000_8001);
        #1 chk("req_timer", 32'(Req), 32'd1);
        cyc();
        mtc0(5'd11, 32'd100);
        #1 chk("ti_clear", 32'(TimerIrq), 32'd0);
        CP0Add = 5'd11;
        #1 chk("compare_rd", CP0Out, 32'd100);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            en = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: CP0Add = 5'd9;
                1: CP0Add = 5'd11;
                2: CP0Add = 5'd12;
                3: CP0Add = 5'd13;
                4: CP0Add = 5'd14;
                5: CP0Add = 5'd15;
                6: CP0Add = 5'($urandom);
                default: CP0Add = 5'd12;
            endcase
            if (CP0Add == 5'd11) CP0In = m_count + 32'($urandom_range(1, 8));
            else if (CP0Add == 5'd9) CP0In = m_compare - 32'($urandom_range(1, 4));
            else CP0In = $urandom;
            if ($urandom_range(0, 7) == 0) HWInt = NHW'($urandom);
            ExcCodeIn = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            EXLClr = ($urandom_range(0, 5) == 0);
            BDIn = 1'($urandom);
            VPC = 32'($urandom) & 32'hFFFF_FFFC;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
